// File: rtl/fp_add_result_stage.sv
// Result stage after the combinational FP adder: repairs special cases, raises status flags
// and buffers {result, flags} in a small FIFO with valid/ready handshakes.
module fp_add_result_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [31:0]      raw_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [CNT_W-1:0] op_count_q;
  logic [35:0]      mem_q [DEPTH];

  logic        push, pop;
  logic [31:0] fix_result;
  logic [3:0]  fix_flags;

  logic       sa, sb;
  logic [7:0] ea, eb, es, max_e;
  logic [22:0] ma, mb;
  logic       a_nan, b_nan, a_inf, b_inf;

  assign sa = a[31];
  assign sb = b[31];
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign es = raw_sum[30:23];
  assign ma = a[22:0];
  assign mb = b[22:0];
  assign max_e = (ea > eb) ? ea : eb;
  assign a_nan = (ea == 8'hFF) && (ma != '0);
  assign b_nan = (eb == 8'hFF) && (mb != '0);
  assign a_inf = (ea == 8'hFF) && (ma == '0);
  assign b_inf = (eb == 8'hFF) && (mb == '0);

  // Flags are {invalid, overflow, underflow, zero}; first matching rule wins.
  always_comb begin
    fix_result = raw_sum;
    fix_flags  = 4'b0000;
    if (a_nan || b_nan) begin
      fix_result = 32'h7FC0_0000;
      fix_flags  = 4'b1000;
    end else if (a_inf && b_inf && (sa != sb)) begin
      fix_result = 32'h7FC0_0000;
      fix_flags  = 4'b1000;
    end else if (a_inf) begin
      fix_result = a;
    end else if (b_inf) begin
      fix_result = b;
    end else if ((ea == 8'h00) && (eb == 8'h00)) begin
      fix_result = {sa & sb, 31'b0};
      fix_flags  = 4'b0001;
    end else if (ea == 8'h00) begin
      fix_result = b;
    end else if (eb == 8'h00) begin
      fix_result = a;
    end else if ((ea == eb) && (ma == mb) && (sa != sb)) begin
      fix_result = 32'h0000_0000;
      fix_flags  = 4'b0001;
    end else if ((sa != sb) && (es > max_e)) begin
      // Effective subtraction cannot grow the exponent: the adder lost a cancellation.
      fix_result = {raw_sum[31], 31'b0};
      fix_flags  = 4'b0011;
    end else if (es == 8'h00) begin
      fix_result = {raw_sum[31], 31'b0};
      fix_flags  = 4'b0011;
    end else if (es == 8'hFF) begin
      fix_result = {raw_sum[31], 8'hFF, 23'b0};
      fix_flags  = 4'b0100;
    end
  end

  assign in_ready  = (count_q != FullCnt);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        op_count_q <= op_count_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {fix_result, fix_flags};
    end
  end

  assign out_result = out_valid ? mem_q[rd_ptr_q][35:4] : 32'h0;
  assign out_flags  = out_valid ? mem_q[rd_ptr_q][3:0] : 4'h0;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_fp_add_result_stage.sv
// Bench for fp_add_result_stage: directed cases plus randomized traffic checked against a
// queue-based reference model of the fix-up rules and FIFO ordering.
module tb_fp_add_result_stage;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      a = '0, b = '0, raw_sum = '0;
  logic             in_ready, out_valid;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] op_count;

  int tests = 0;
  int fails = 0;
  logic [35:0]      q[$];
  logic [CNT_W-1:0] m_cnt = '0;

  fp_add_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .raw_sum(raw_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference: decode fields arithmetically and apply the repair rules in priority order.
  function automatic logic [35:0] ref_fix(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] s);
    int unsigned ex, ey, es, mx, my, big;
    bit sx, sy, xnan, ynan, xinf, yinf;
    logic [31:0] sz;
    ex = (x >> 23) & 255; ey = (y >> 23) & 255; es = (s >> 23) & 255;
    mx = x & 32'h007F_FFFF; my = y & 32'h007F_FFFF;
    sx = (x >= 32'h8000_0000); sy = (y >= 32'h8000_0000);
    xnan = (ex == 255) && (mx != 0); ynan = (ey == 255) && (my != 0);
    xinf = (ex == 255) && (mx == 0); yinf = (ey == 255) && (my == 0);
    big = (ex > ey) ? ex : ey;
    sz = s & 32'h8000_0000;
    if (xnan || ynan) return {32'h7FC0_0000, 4'b1000};
    if (xinf && yinf && sx != sy) return {32'h7FC0_0000, 4'b1000};
    if (xinf) return {x, 4'b0000};
    if (yinf) return {y, 4'b0000};
    if (ex == 0 && ey == 0) return {((sx && sy) ? 32'h8000_0000 : 32'h0), 4'b0001};
    if (ex == 0) return {y, 4'b0000};
    if (ey == 0) return {x, 4'b0000};
    if ((x & 32'h7FFF_FFFF) == (y & 32'h7FFF_FFFF) && sx != sy) return {32'h0, 4'b0001};
    if (sx != sy && es > big) return {sz, 4'b0011};
    if (es == 0) return {sz, 4'b0011};
    if (es == 255) return {sz | 32'h7F80_0000, 4'b0100};
    return {s, 4'b0000};
  endfunction

  task automatic check_out(input string tag);
    logic [35:0] head;
    bit          vld;
    vld  = (q.size() != 0);
    head = vld ? q[0] : 36'h0;
    tests++;
    assert (out_valid === vld) else begin
      fails++; $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, vld);
    end
    tests++;
    assert (out_result === head[35:4]) else begin
      fails++; $error("FAIL %s out_result: got %h expected %h", tag, out_result, head[35:4]);
    end
    tests++;
    assert (out_flags === head[3:0]) else begin
      fails++; $error("FAIL %s out_flags: got %b expected %b", tag, out_flags, head[3:0]);
    end
    tests++;
    assert (in_ready === (q.size() != DEPTH)) else begin
      fails++; $error("FAIL %s in_ready: got %b expected %b", tag, in_ready, q.size() != DEPTH);
    end
    tests++;
    assert (op_count === m_cnt) else begin
      fails++; $error("FAIL %s op_count: got %0d expected %0d", tag, op_count, m_cnt);
    end
  endtask

  // Independent constant check of the FIFO head for the directed vectors.
  task automatic expect_head(input string tag, input logic [31:0] res, input logic [3:0] flg);
    tests++;
    assert (out_valid === 1'b1 && out_result === res && out_flags === flg) else begin
      fails++;
      $error("FAIL %s head: got v=%b %h/%b expected v=1 %h/%b", tag, out_valid, out_result,
             out_flags, res, flg);
    end
  endtask

  task automatic cycle(input string tag, input logic v, input logic [31:0] ta,
                       input logic [31:0] tb2, input logic [31:0] ts, input logic r);
    bit push, pop;
    logic [35:0] e;
    in_valid = v; a = ta; b = tb2; raw_sum = ts; out_ready = r;
    push = v && (q.size() != DEPTH);
    pop  = r && (q.size() != 0);
    e    = ref_fix(ta, tb2, ts);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      m_cnt++;
    end
    #1;
    check_out(tag);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    q.delete(); m_cnt = '0;
    @(posedge clk); #1;
    check_out("reset");
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'hFE;
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  initial begin
    logic [31:0] ra, rb, rs;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("por");
    reset = 1'b1;

    // Plain add, then special cases streamed with out_ready held high.
    cycle("t1", 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1);
    expect_head("t1", 32'h4040_0000, 4'b0000);
    tests++;
    assert (op_count === 16'd1) else begin
      fails++; $error("FAIL t1 op_count: got %0d expected 1", op_count);
    end
    cycle("nan", 1, 32'h7FC0_0001, 32'h3F80_0000, 32'h1234_5678, 1);
    expect_head("nan", 32'h7FC0_0000, 4'b1000);
    cycle("infinf", 1, 32'h7F80_0000, 32'hFF80_0000, 32'h1234_5678, 1);
    expect_head("infinf", 32'h7FC0_0000, 4'b1000);
    cycle("inf", 1, 32'h7F80_0000, 32'h3F80_0000, 32'h1234_5678, 1);
    expect_head("inf", 32'h7F80_0000, 4'b0000);
    cycle("cancel", 1, 32'h3F80_0000, 32'hBF80_0000, 32'hDEAD_BEEF, 1);
    expect_head("cancel", 32'h0000_0000, 4'b0001);
    cycle("negzero", 1, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 1);
    expect_head("negzero", 32'h8000_0000, 4'b0001);
    cycle("zero_a", 1, 32'h0000_0000, 32'h40A0_0000, 32'hDEAD_BEEF, 1);
    expect_head("zero_a", 32'h40A0_0000, 4'b0000);
    cycle("ovf", 1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1);
    expect_head("ovf", 32'h7F80_0000, 4'b0100);
    cycle("unf", 1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0001, 1);
    expect_head("unf", 32'h0000_0000, 4'b0011);
    cycle("drain", 0, '0, '0, '0, 1);
    cycle("empty_pop", 0, '0, '0, '0, 1);

    // Back-pressure: third push must be refused, order preserved on drain.
    do_reset();
    cycle("fill_x", 1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0);
    cycle("fill_y", 1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0);
    tests++;
    assert (in_ready === 1'b0) else begin
      fails++; $error("FAIL full in_ready: got %b expected 0", in_ready);
    end
    cycle("fill_z", 1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1);
    expect_head("pop_y", 32'h4080_0000, 4'b0000);
    tests++;
    assert (op_count === 16'd2) else begin
      fails++; $error("FAIL full op_count: got %0d expected 2", op_count);
    end
    cycle("drain_y", 0, '0, '0, '0, 1);

    // Asynchronous reset in the middle of a cycle drops buffered data.
    cycle("pre_rst", 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    assert (out_valid === 1'b0 && op_count === '0 && out_result === '0) else begin
      fails++;
      $error("FAIL async_rst: got v=%b cnt=%0d res=%h expected v=0 cnt=0 res=0", out_valid,
             op_count, out_result);
    end
    q.delete(); m_cnt = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    cycle("post_rst", 1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0);
    expect_head("post_rst", 32'h4080_0000, 4'b0000);
    cycle("post_rst2", 0, '0, '0, '0, 1);

    // Randomized traffic with random handshakes.
    for (int i = 0; i < 400; i++) begin
      ra = rand_fp();
      rb = ($urandom_range(0, 7) == 0) ? (ra ^ 32'h8000_0000) : rand_fp();
      rs = rand_fp();
      cycle("rand", 1'($urandom), ra, rb, rs, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
